// File: rtl/nf10_rate_limiter_tb_bucket_if.sv
// nf10_rate_limiter_tb_bucket_if
// AXI4-Stream bundle used on both sides of the token-bucket rate limiter.
// The master modport drives payload and valid; the slave modport drives ready.

interface nf10_rate_limiter_tb_bucket_if #(
    parameter int DATA_WIDTH  = 256,
    parameter int TUSER_WIDTH = 128
);
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tstrb;
    logic [TUSER_WIDTH-1:0]  tuser;
    logic                    tvalid;
    logic                    tready;
    logic                    tlast;

    modport master (
        output tdata,
        output tstrb,
        output tuser,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tstrb,
        input  tuser,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/nf10_rate_limiter_tb_bucket.sv
// nf10_rate_limiter_tb_bucket
// Token-bucket rate limiter sitting inline on a 256-bit AXI4-Stream path.
// The datapath is a zero-latency passthrough; a new packet is admitted only at a
// packet boundary and only while the bucket holds a positive token count. A packet
// already in flight always completes, so the bucket may run into deficit.
// Tokens are charged per byte (popcount of tstrb) or per packet (pkt_mode).
// Define RATE_LIMITER_STATS_EN to build the stat_pkts/stat_bytes/stat_throttle
// counters; without it those ports and their logic do not exist.
// The s/m stream widths must match; the interface instance fixes them.

module nf10_rate_limiter_tb_bucket #(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXI_DATA_WIDTH   = 32,
    parameter int C_TOKEN_WIDTH        = 24
) (
    input  logic                                 axi_aclk,
    input  logic                                 axi_areset,
    nf10_rate_limiter_tb_bucket_if.slave         s_axis,
    nf10_rate_limiter_tb_bucket_if.master        m_axis,
    input  logic                                 sw_rst,
    input  logic                                 rate_lim_en,
    input  logic                                 pkt_mode,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]        tick_period,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]        tokens_per_tick,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]        bucket_depth,
    output logic signed [C_TOKEN_WIDTH:0]        tokens
`ifdef RATE_LIMITER_STATS_EN
    ,
    output logic [31:0]                          stat_pkts,
    output logic [31:0]                          stat_bytes,
    output logic [31:0]                          stat_throttle
`endif
);

    localparam int TW     = C_TOKEN_WIDTH;
    localparam int SW     = C_TOKEN_WIDTH + 2;
    localparam int STRB_W = C_S_AXIS_DATA_WIDTH / 8;
    localparam int CW     = $clog2(STRB_W + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PASS = 1'b1;

    // Most negative level the bucket may reach: -(2^TW)
    localparam logic signed [SW-1:0] TOK_FLOOR = {2'b11, {TW{1'b0}}};

    localparam bit CFG_OK = (C_M_AXIS_DATA_WIDTH == C_S_AXIS_DATA_WIDTH) &&
                            (C_M_AXIS_TUSER_WIDTH == C_S_AXIS_TUSER_WIDTH) &&
                            (C_S_AXI_DATA_WIDTH > C_TOKEN_WIDTH);

    logic [0:0]             state;
    logic                   loaded;
    logic signed [TW:0]     tok_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] tick_cnt;

    logic                   rst_any;
    logic                   refill;
    logic                   admit;
    logic                   gate;
    logic                   xfer;
    logic [CW-1:0]          strb_cnt;
    logic [TW-1:0]          depth_lo;
    logic [TW-1:0]          add_lo;
    logic signed [SW-1:0]   depth_ext;
    logic signed [SW-1:0]   tok_ext;
    logic signed [SW-1:0]   add_ext;
    logic signed [SW-1:0]   cost_ext;
    logic signed [SW-1:0]   sum;
    logic signed [SW-1:0]   tok_next;

    logic unused_cfg;
    assign unused_cfg = CFG_OK ^ (^bucket_depth[C_S_AXI_DATA_WIDTH-1:TW]);

    // Until the first clock after a reset the bucket reads as full at whatever
    // depth is configured; this avoids an asynchronous load of a port value.
    assign depth_lo = bucket_depth[TW-1:0];
    assign tokens   = loaded ? tok_q : {1'b0, depth_lo};

    // A refill larger than the counter could ever hold only matters up to the cap
    assign add_lo = (|tokens_per_tick[C_S_AXI_DATA_WIDTH-1:TW]) ? {TW{1'b1}}
                                                                : tokens_per_tick[TW-1:0];

    assign rst_any = axi_areset | sw_rst;
    assign admit   = !rate_lim_en | (!tokens[TW] & (|tokens));
    assign gate    = !rst_any & ((state == ST_PASS) | admit);
    assign xfer    = s_axis.tvalid & m_axis.tready & gate;
    assign refill  = (tick_cnt >= tick_period);

    assign m_axis.tdata  = s_axis.tdata;
    assign m_axis.tstrb  = s_axis.tstrb;
    assign m_axis.tuser  = s_axis.tuser;
    assign m_axis.tlast  = s_axis.tlast;
    assign m_axis.tvalid = s_axis.tvalid & gate;
    assign s_axis.tready = m_axis.tready & gate;

    // Count valid bytes in the current beat
    always_comb begin
        strb_cnt = '0;
        for (int i = 0; i < STRB_W; i++) begin
            strb_cnt = strb_cnt + CW'(s_axis.tstrb[i]);
        end
    end

    // Next bucket level: refill minus cost, clamped to [-(2^TW), bucket_depth]
    always_comb begin
        cost_ext  = '0;
        if (xfer && rate_lim_en) begin
            if (pkt_mode) begin
                cost_ext = {{(SW-1){1'b0}}, s_axis.tlast};
            end else begin
                cost_ext = SW'(strb_cnt);
            end
        end
        depth_ext = $signed({2'b00, depth_lo});
        tok_ext   = {tokens[TW], tokens};
        add_ext   = refill ? $signed({2'b00, add_lo}) : '0;
        sum       = tok_ext + add_ext - cost_ext;
        if (sum > depth_ext) begin
            tok_next = depth_ext;
        end else if (sum < TOK_FLOOR) begin
            tok_next = TOK_FLOOR;
        end else begin
            tok_next = sum;
        end
    end

    // Refill interval counter; a shrunken tick_period forces an immediate wrap
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            tick_cnt <= '0;
        end else if (sw_rst) begin
            tick_cnt <= '0;
        end else if (refill) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // Bucket level register
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            tok_q  <= '0;
            loaded <= 1'b0;
        end else if (sw_rst) begin
            tok_q  <= '0;
            loaded <= 1'b0;
        end else begin
            tok_q  <= tok_next[TW:0];
            loaded <= 1'b1;
        end
    end

    // Packet boundary tracking so gating only ever applies between packets
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            state <= ST_IDLE;
        end else if (sw_rst) begin
            state <= ST_IDLE;
        end else if (xfer) begin
            state <= s_axis.tlast ? ST_IDLE : ST_PASS;
        end
    end

`ifdef RATE_LIMITER_STATS_EN
    // Free-running traffic statistics, wrapping at 2^32
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            stat_pkts     <= '0;
            stat_bytes    <= '0;
            stat_throttle <= '0;
        end else if (sw_rst) begin
            stat_pkts     <= '0;
            stat_bytes    <= '0;
            stat_throttle <= '0;
        end else begin
            if (xfer && s_axis.tlast) begin
                stat_pkts <= stat_pkts + 32'd1;
            end
            if (xfer) begin
                stat_bytes <= stat_bytes + 32'(strb_cnt);
            end
            if (s_axis.tvalid && m_axis.tready && !gate) begin
                stat_throttle <= stat_throttle + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_nf10_rate_limiter_tb_bucket.sv
// tb_nf10_rate_limiter_tb_bucket
// Randomized bench for the token-bucket rate limiter. A behavioural bucket model
// (integer token level, packet-in-flight flag, cycles-since-refill) predicts the
// handshake and token level every cycle.

module tb_nf10_rate_limiter_tb_bucket;

    localparam int DW = 256;
    localparam int UW = 128;
    localparam int TW = 24;

    logic axi_aclk = 1'b0;
    logic axi_areset;
    logic sw_rst;
    logic rate_lim_en;
    logic pkt_mode;
    logic [31:0] tick_period;
    logic [31:0] tokens_per_tick;
    logic [31:0] bucket_depth;
    logic signed [TW:0] tokens;
`ifdef RATE_LIMITER_STATS_EN
    logic [31:0] stat_pkts;
    logic [31:0] stat_bytes;
    logic [31:0] stat_throttle;
`endif

    always #5 axi_aclk = ~axi_aclk;

    nf10_rate_limiter_tb_bucket_if #(.DATA_WIDTH(DW), .TUSER_WIDTH(UW)) s_if ();
    nf10_rate_limiter_tb_bucket_if #(.DATA_WIDTH(DW), .TUSER_WIDTH(UW)) m_if ();

    nf10_rate_limiter_tb_bucket dut (
        .axi_aclk        (axi_aclk),
        .axi_areset      (axi_areset),
        .s_axis          (s_if),
        .m_axis          (m_if),
        .sw_rst          (sw_rst),
        .rate_lim_en     (rate_lim_en),
        .pkt_mode        (pkt_mode),
        .tick_period     (tick_period),
        .tokens_per_tick (tokens_per_tick),
        .bucket_depth    (bucket_depth),
        .tokens          (tokens)
`ifdef RATE_LIMITER_STATS_EN
        ,
        .stat_pkts       (stat_pkts),
        .stat_bytes      (stat_bytes),
        .stat_throttle   (stat_throttle)
`endif
    );

    int checks = 0;
    int failures = 0;

    // Reference model state
    longint m_tok;
    longint m_since;
    bit     m_in_pkt;
    longint m_stat_pkts;
    longint m_stat_bytes;
    longint m_stat_throttle;

    // Source generator state
    int valid_pct;
    int ready_pct;
    int pkt_bytes;
    int pkt_len;
    int beat_idx;
    bit holding;

    // Per-phase observations
    int     dut_beats;
    int     mdl_beats;
    int     dut_pkts;
    int     mdl_pkts;
    longint dut_min_tok;

    task automatic checkOutput(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        m_tok           = longint'(bucket_depth[TW-1:0]);
        m_since         = 0;
        m_in_pkt        = 1'b0;
        m_stat_pkts     = 0;
        m_stat_bytes    = 0;
        m_stat_throttle = 0;
    endtask

    task automatic newPacket();
        pkt_len  = (pkt_bytes > 0) ? (pkt_bytes + 31) / 32 : $urandom_range(1, 5);
        beat_idx = 0;
    endtask

    task automatic restartSource();
        s_if.tvalid = 1'b0;
        holding     = 1'b0;
        newPacket();
    endtask

    task automatic clearCounts();
        dut_beats   = 0;
        mdl_beats   = 0;
        dut_pkts    = 0;
        mdl_pkts    = 0;
        dut_min_tok = longint'(tokens);
    endtask

    function automatic logic [31:0] lastStrb(input int bytes);
        logic [31:0] s;
        s = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < bytes) s[i] = 1'b1;
        end
        return s;
    endfunction

    // One clock cycle: drive, compare against the model, advance the model.
    // Entered shortly after a rising edge, returns 1 time unit after the next one.
    task automatic applyStimulus();
        bit     admit;
        bit     gate;
        bit     xfer;
        bit     refill;
        bit     same;
        longint cost;
        longint add;
        longint lo;
        int     rem;

        if (!holding) begin
            if ($urandom_range(99) < valid_pct) begin
                s_if.tvalid = 1'b1;
                s_if.tdata  = {8{$urandom}};
                s_if.tuser  = {4{$urandom}};
                s_if.tlast  = (beat_idx == pkt_len - 1);
                if (pkt_bytes > 0) begin
                    rem = pkt_bytes - 32 * beat_idx;
                    s_if.tstrb = (rem >= 32) ? 32'hFFFF_FFFF : lastStrb(rem);
                end else begin
                    s_if.tstrb = $urandom;
                end
            end else begin
                s_if.tvalid = 1'b0;
            end
        end
        m_if.tready = ($urandom_range(99) < ready_pct);
        #1;

        admit = !rate_lim_en || (m_tok > 0);
        gate  = m_in_pkt || admit;
        xfer  = s_if.tvalid && m_if.tready && gate;

        checkOutput("m_tvalid", longint'(m_if.tvalid), longint'(s_if.tvalid && gate));
        checkOutput("s_tready", longint'(s_if.tready), longint'(m_if.tready && gate));
        checkOutput("tokens", longint'(tokens), m_tok);
        if (s_if.tvalid) begin
            same = (m_if.tdata == s_if.tdata) && (m_if.tstrb == s_if.tstrb) &&
                   (m_if.tuser == s_if.tuser) && (m_if.tlast == s_if.tlast);
            checkOutput("passthrough", longint'(same), 1);
        end

        if (longint'(tokens) < dut_min_tok) dut_min_tok = longint'(tokens);
        if (s_if.tvalid && s_if.tready) begin
            dut_beats++;
            if (s_if.tlast) dut_pkts++;
        end
        if (xfer) begin
            mdl_beats++;
            if (s_if.tlast) mdl_pkts++;
        end

        // Bucket rules
        refill  = (m_since >= longint'(tick_period));
        m_since = refill ? 0 : m_since + 1;
        cost = 0;
        if (xfer && rate_lim_en) begin
            cost = pkt_mode ? longint'(s_if.tlast) : longint'($countones(s_if.tstrb));
        end
        add = 0;
        if (refill) begin
            add = (tokens_per_tick > 32'h00FF_FFFF) ? longint'(32'h00FF_FFFF)
                                                    : longint'(tokens_per_tick);
        end
        lo    = -(longint'(1) << TW);
        m_tok = m_tok + add - cost;
        if (m_tok > longint'(bucket_depth[TW-1:0])) m_tok = longint'(bucket_depth[TW-1:0]);
        if (m_tok < lo) m_tok = lo;
        if (xfer) m_in_pkt = !s_if.tlast;

        if (xfer && s_if.tlast) m_stat_pkts++;
        if (xfer) m_stat_bytes += $countones(s_if.tstrb);
        if (s_if.tvalid && m_if.tready && !gate) m_stat_throttle++;

        // Source follows the DUT's handshake, holding a beat until it is taken
        if (s_if.tvalid) begin
            if (s_if.tready) begin
                holding = 1'b0;
                if (s_if.tlast) newPacket();
                else beat_idx++;
            end else begin
                holding = 1'b1;
            end
        end

        @(posedge axi_aclk);
        #1;
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus();
    endtask

    task automatic doSoftReset();
        m_if.tready = 1'b1;
        sw_rst = 1'b1;
        #1;
        checkOutput("swrst_tvalid", longint'(m_if.tvalid), 0);
        checkOutput("swrst_tready", longint'(s_if.tready), 0);
        @(posedge axi_aclk);
        #1;
        sw_rst = 1'b0;
        modelReset();
        restartSource();
        checkOutput("swrst_tokens", longint'(tokens), longint'(bucket_depth[TW-1:0]));
    endtask

    task automatic doAsyncReset();
        m_if.tready = 1'b1;
        axi_areset = 1'b1;
        #1;
        checkOutput("arst_tvalid", longint'(m_if.tvalid), 0);
        checkOutput("arst_tready", longint'(s_if.tready), 0);
        checkOutput("arst_tokens", longint'(tokens), longint'(bucket_depth[TW-1:0]));
        #1;
        axi_areset = 1'b0;
        modelReset();
        restartSource();
    endtask

    task automatic waitMidPacket();
        for (int i = 0; i < 200; i++) begin
            if (beat_idx > 0) break;
            applyStimulus();
        end
    endtask

    initial begin
        axi_areset      = 1'b1;
        sw_rst          = 1'b0;
        rate_lim_en     = 1'b0;
        pkt_mode        = 1'b0;
        tick_period     = 32'd3;
        tokens_per_tick = 32'd5;
        bucket_depth    = 32'd100;
        s_if.tvalid     = 1'b0;
        s_if.tdata      = '0;
        s_if.tstrb      = '0;
        s_if.tuser      = '0;
        s_if.tlast      = 1'b0;
        m_if.tready     = 1'b1;
        valid_pct       = 100;
        ready_pct       = 100;
        pkt_bytes       = 64;
        restartSource();

        repeat (3) @(posedge axi_aclk);
        #1;
        s_if.tvalid = 1'b1;
        #1;
        checkOutput("reset_tvalid", longint'(m_if.tvalid), 0);
        checkOutput("reset_tready", longint'(s_if.tready), 0);
        checkOutput("reset_tokens", longint'(tokens), 100);
        axi_areset = 1'b0;
        modelReset();
        restartSource();

        // Transparent: 10 back-to-back 64 B packets
        clearCounts();
        runCycles(20);
        checkOutput("transparent_beats", dut_beats, 20);
        checkOutput("transparent_tokens", longint'(tokens), 100);

        // Byte mode, 1500 B packets at 3.2 B/cycle
        rate_lim_en     = 1'b1;
        pkt_mode        = 1'b0;
        tick_period     = 32'd9;
        tokens_per_tick = 32'd32;
        bucket_depth    = 32'd64;
        pkt_bytes       = 1500;
        doSoftReset();
        clearCounts();
        runCycles(2500);
        checkOutput("byte_deficit", longint'(dut_min_tok < 0), 1);
        checkOutput("byte_pkts", dut_pkts, mdl_pkts);

        // Packet mode, 1 token per 100 cycles, depth 2
        pkt_mode        = 1'b1;
        tick_period     = 32'd99;
        tokens_per_tick = 32'd1;
        bucket_depth    = 32'd2;
        pkt_bytes       = 32;
        doSoftReset();
        clearCounts();
        runCycles(500);
        checkOutput("pkt_mode_pkts", dut_pkts, 6);
        checkOutput("pkt_mode_model", dut_pkts, mdl_pkts);

        // Mid-packet deficit: 40 tokens, 128 B packet, no refills
        pkt_mode        = 1'b0;
        tick_period     = 32'd1000;
        tokens_per_tick = 32'd0;
        bucket_depth    = 32'd40;
        pkt_bytes       = 128;
        doSoftReset();
        clearCounts();
        runCycles(20);
        checkOutput("midpkt_beats", dut_beats, 4);
        checkOutput("midpkt_tokens", longint'(tokens), -88);
        checkOutput("midpkt_held", longint'(s_if.tready), 0);

        // Randomized segments with backpressure, config changes and resets
        valid_pct = 70;
        ready_pct = 50;
        pkt_bytes = 0;
        clearCounts();
        for (int seg = 0; seg < 8; seg++) begin
            rate_lim_en     = ($urandom_range(3) != 0);
            pkt_mode        = $urandom_range(1);
            tick_period     = (seg == 4) ? 32'd60 : 32'($urandom_range(0, 7));
            tokens_per_tick = 32'($urandom_range(0, 40));
            bucket_depth    = 32'($urandom_range(1, 200));
            if (seg == 3) begin
                waitMidPacket();
                doSoftReset();
            end
            if (seg == 6) begin
                waitMidPacket();
                doAsyncReset();
            end
            runCycles(150);
            if (seg == 4) tick_period = 32'd2;
            if (seg == 5) bucket_depth = 32'd5;
            runCycles(150);
        end
        checkOutput("random_beats", dut_beats, mdl_beats);
        checkOutput("random_pkts", dut_pkts, mdl_pkts);

`ifdef RATE_LIMITER_STATS_EN
        checkOutput("stat_pkts", longint'(stat_pkts), m_stat_pkts & 64'hFFFF_FFFF);
        checkOutput("stat_bytes", longint'(stat_bytes), m_stat_bytes & 64'hFFFF_FFFF);
        checkOutput("stat_throttle", longint'(stat_throttle), m_stat_throttle & 64'hFFFF_FFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nf10_rate_limiter_tb_bucket.md
Name: nf10_rate_limiter_tb_bucket

Overview:
- Token-bucket AXI4-Stream rate limiter; successor to the simple single-rate limiter.
- Sits inline on a 256-bit datapath between a packet source and the output queue; configuration arrives as flat ports driven by the wrapper's AXI-Lite register block.
- Adds a configurable burst depth, byte-accurate accounting from tstrb, per-packet gating, and a packets-only mode.

Parameters:
- C_M_AXIS_DATA_WIDTH, 256, master tdata width.
- C_S_AXIS_DATA_WIDTH, 256, slave tdata width; must equal C_M_AXIS_DATA_WIDTH.
- C_M_AXIS_TUSER_WIDTH, 128, master tuser width.
- C_S_AXIS_TUSER_WIDTH, 128, slave tuser width; must equal C_M_AXIS_TUSER_WIDTH.
- C_S_AXI_DATA_WIDTH, 32, configuration word width.
- C_TOKEN_WIDTH, 24, magnitude width of the token counter.

Ports:
- axi_aclk  in  1  clock
- axi_areset  in  1  asynchronous reset, active-high
- s_axis_tdata/tstrb/tuser/tvalid/tlast  in  per params  input stream
- s_axis_tready  out  1  input ready
- m_axis_tdata/tstrb/tuser/tvalid/tlast  out  per params  output stream
- m_axis_tready  in  1  output ready
- sw_rst  in  1  synchronous soft reset, active-high
- rate_lim_en  in  1  1 = limit, 0 = transparent
- pkt_mode  in  1  1 = one token per packet, 0 = one token per byte
- tick_period  in  C_S_AXI_DATA_WIDTH  cycles between refills, minus 1
- tokens_per_tick  in  C_S_AXI_DATA_WIDTH  tokens added per refill
- bucket_depth  in  C_S_AXI_DATA_WIDTH  token cap; only the low C_TOKEN_WIDTH bits are used
- tokens  out  C_TOKEN_WIDTH+1  current signed token level

Behaviour:
- Reset (axi_areset or sw_rst): state = IDLE; tokens = bucket_depth; tick_cnt = 0. Outputs: s_axis_tready = 0, m_axis_tvalid = 0.
- Datapath is combinational passthrough with zero latency:
  - m_axis_tdata/tstrb/tuser/tlast = s_axis_*.
  - m_axis_tvalid = s_axis_tvalid & gate.
  - s_axis_tready = m_axis_tready & gate.
  - A beat transfers when s_axis_tvalid & s_axis_tready.
- gate = (state == PASS) | (state == IDLE & admit).
  - admit = !rate_lim_en | (tokens > 0).
- State machine, gating happens only at packet boundaries:
  - IDLE -> PASS on a transferred beat with tlast = 0.
  - IDLE stays IDLE on a transferred single-beat packet (tlast = 1).
  - PASS -> IDLE on a transferred beat with tlast = 1.
  - A packet in flight is never stalled by the limiter.
- Refill timing:
  - tick_cnt counts 0..tick_period, then wraps to 0 and asserts refill for one cycle.
  - tick_period = 0 means refill every cycle.
  - Writing a smaller tick_period while tick_cnt > tick_period forces a wrap on the next cycle.
- Token consumption per transferred beat:
  - Byte mode: cost = popcount(s_axis_tstrb), range 0..32.
  - Packet mode: cost = 1 on a tlast beat, else 0.
- Token update:
  - Refill and cost in the same cycle: next = tokens + (refill ? tokens_per_tick : 0) - cost, computed at C_TOKEN_WIDTH+2 bits.
  - Saturate at the top to bucket_depth.
  - Saturate at the bottom to -(2^C_TOKEN_WIDTH). The bucket may go negative (deficit) within a packet; the next packet waits until tokens > 0.
- rate_lim_en = 0:
  - Tokens still refill and are never consumed, so the bucket sits full at re-enable.
- bucket_depth reduced below the current level: clamp to the new depth on the next cycle.

Optional Feature:
- Macro: RATE_LIMITER_STATS_EN.
- With the macro defined:
  - Extra outputs stat_pkts[31:0], stat_bytes[31:0], stat_throttle[31:0].
  - stat_pkts counts transferred tlast beats; stat_bytes accumulates popcount(tstrb); stat_throttle counts cycles with s_axis_tvalid & m_axis_tready & !gate.
  - All three wrap at 2^32 and clear on either reset.
- Without the macro: the ports and logic are absent.

Test Plan:
- Transparent mode: rate_lim_en = 0, 10 back-to-back 64 B packets (2 beats each) -> 20 beats out in 20 cycles, tokens stay at bucket_depth.
- Byte mode: tick_period = 9, tokens_per_tick = 32, bucket_depth = 64, 1500 B packets -> after the first burst, the average gap between packets is ~470 cycles (1500 B at 3.2 B/cycle), and tokens go negative and recover.
- Packet mode: pkt_mode = 1, tick_period = 99, tokens_per_tick = 1, bucket_depth = 2, continuous 1-beat packets -> 2 packets immediately, then 1 packet per 100 cycles.
- Mid-packet: tokens reach ≤ 0 during a 4-beat packet -> all 4 beats pass with m_axis_tready = 1 throughout, the next packet is held with s_axis_tready = 0.
- Backpressure: m_axis_tready toggling 50% while gate = 1 -> no beat lost or duplicated, cost is charged only on transferred beats.
- Reset: axi_areset or sw_rst asserted mid-packet -> s_axis_tready = 0 and m_axis_tvalid = 0 immediately, tokens = bucket_depth, state = IDLE.
